// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   ctrl_state_e : FSM encodings RUN/WAIT/FAULT (2'd3 is illegal, recovers to RUN)
//   CTRL_STATE_W : width of the exported debug state
//   REG_X0       : architectural zero register, never a real dependency
package hazard_pkg;

  localparam int CTRL_STATE_W = 2;
  localparam logic [4:0] REG_X0 = 5'd0;

  typedef enum logic [CTRL_STATE_W-1:0] {
    RUN   = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } ctrl_state_e;

endpackage

// File: rtl/load_use_detect.sv
// Combinational load-use hazard term: the EX instruction is a load whose
// destination (other than x0) is read by the ID instruction.
// Ports:
//   ID_rs1Addr/ID_rs2Addr  in  source registers of the ID instruction
//   ID_rs1Used/ID_rs2Used  in  the ID instruction actually reads that source
//   EX_memRead             in  EX instruction is a load
//   EX_rdAddr              in  destination of the EX instruction
//   loadUse                out hazard present this cycle
module load_use_detect
  import hazard_pkg::*;
(
  input  logic [4:0] ID_rs1Addr,
  input  logic [4:0] ID_rs2Addr,
  input  logic       ID_rs1Used,
  input  logic       ID_rs2Used,
  input  logic       EX_memRead,
  input  logic [4:0] EX_rdAddr,
  output logic       loadUse
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit = ID_rs1Used & (EX_rdAddr == ID_rs1Addr);
  assign rs2_hit = ID_rs2Used & (EX_rdAddr == ID_rs2Addr);
  assign loadUse = EX_memRead & (EX_rdAddr != REG_X0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline. Covers the hazards
// forwarding cannot: load-use bubble, taken-branch flush, and data-memory
// wait states with timeout supervision.
// Optional feature: define HAZARD_PERF_CNT_EN to add saturating performance
// counters (perfStallCycles, perfLoadUse, perfFlushes).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   ID_*, EX_memRead/rdAddr  operands for load-use detection
//   EX_branchTaken           branch/jump resolved taken in EX
//   MEM_memReq/MEM_memReady  data-memory access handshake
//   faultClear               leave FAULT state
//   PC_En, *_En, *_Flush     pipeline control; Mealy, act at the next edge
//   memFault                 sticky timeout flag
//   ctrlState                current FSM state (debug)
// Memory handshake: an access stalls the pipeline whenever MEM_memReq is high
// and MEM_memReady is low; MEM_memReady without MEM_memReq carries no meaning.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4:0]              ID_rs1Addr,
  input  logic [4:0]              ID_rs2Addr,
  input  logic                    ID_rs1Used,
  input  logic                    ID_rs2Used,
  input  logic                    EX_memRead,
  input  logic [4:0]              EX_rdAddr,
  input  logic                    EX_branchTaken,
  input  logic                    MEM_memReq,
  input  logic                    MEM_memReady,
  input  logic                    faultClear,
  output logic                    PC_En,
  output logic                    IFID_En,
  output logic                    IFID_Flush,
  output logic                    IDEX_En,
  output logic                    IDEX_Flush,
  output logic                    EXMEM_En,
  output logic                    MEMWB_En,
  output logic                    memFault,
  output logic [CTRL_STATE_W-1:0] ctrlState
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]             perfStallCycles,
  output logic [31:0]             perfLoadUse,
  output logic [31:0]             perfFlushes
`endif
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

  ctrl_state_e      state_q, state_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             fault_q, fault_d;
  logic             load_use;
  logic             mem_stall;
  logic             run_eval;

  load_use_detect u_load_use_detect (
    .ID_rs1Addr (ID_rs1Addr),
    .ID_rs2Addr (ID_rs2Addr),
    .ID_rs1Used (ID_rs1Used),
    .ID_rs2Used (ID_rs2Used),
    .EX_memRead (EX_memRead),
    .EX_rdAddr  (EX_rdAddr),
    .loadUse    (load_use)
  );

  assign mem_stall = MEM_memReq & ~MEM_memReady;

  always_comb begin
    PC_En      = 1'b0;
    IFID_En    = 1'b0;
    IFID_Flush = 1'b0;
    IDEX_En    = 1'b0;
    IDEX_Flush = 1'b0;
    EXMEM_En   = 1'b0;
    MEMWB_En   = 1'b0;
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    fault_d    = fault_q;
    run_eval   = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_stall) begin
          state_d    = WAIT;
          wait_cnt_d = CNT_W'(1);
        end else begin
          run_eval = 1'b1;
        end
      end
      WAIT: begin
        // Release in the ready cycle itself so completion costs no extra cycle.
        if (MEM_memReady) begin
          run_eval   = 1'b1;
          state_d    = RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == TIMEOUT_C) begin
          state_d = FAULT;
          fault_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
      end
      FAULT: begin
        if (faultClear) begin
          state_d    = RUN;
          fault_d    = 1'b0;
          wait_cnt_d = '0;
          IFID_Flush = 1'b1;
          IDEX_Flush = 1'b1;
        end
      end
      default: begin
        state_d    = RUN;
        wait_cnt_d = '0;
      end
    endcase

    // Branch wins over load-use: the ID instruction that would consume the
    // load is being squashed anyway.
    if (run_eval) begin
      if (EX_branchTaken) begin
        {PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En} = 5'b11111;
        IFID_Flush = 1'b1;
        IDEX_Flush = 1'b1;
      end else if (load_use) begin
        IDEX_En    = 1'b1;
        IDEX_Flush = 1'b1;
        EXMEM_En   = 1'b1;
        MEMWB_En   = 1'b1;
      end else begin
        {PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En} = 5'b11111;
      end
    end

    if (rst) begin
      {PC_En, IFID_En, IDEX_En, EXMEM_En, MEMWB_En} = 5'b00000;
      IFID_Flush = 1'b1;
      IDEX_Flush = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      wait_cnt_q <= '0;
      fault_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      fault_q    <= fault_d;
    end
  end

  assign memFault  = fault_q;
  assign ctrlState = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_q, perf_lu_q, perf_fl_q;
  logic        lu_fire, br_fire;

  // The bubble is the only pattern with ID/EX loading a flush while PC holds;
  // the branch flush is the only one that flushes while PC advances.
  assign lu_fire = IDEX_En & IDEX_Flush & ~PC_En;
  assign br_fire = PC_En & IFID_Flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= '0;
      perf_lu_q    <= '0;
      perf_fl_q    <= '0;
    end else begin
      if (!PC_En && perf_stall_q != 32'hFFFF_FFFF) perf_stall_q <= perf_stall_q + 32'd1;
      if (lu_fire && perf_lu_q != 32'hFFFF_FFFF)   perf_lu_q    <= perf_lu_q + 32'd1;
      if (br_fire && perf_fl_q != 32'hFFFF_FFFF)   perf_fl_q    <= perf_fl_q + 32'd1;
    end
  end

  assign perfStallCycles = perf_stall_q;
  assign perfLoadUse     = perf_lu_q;
  assign perfFlushes     = perf_fl_q;
`endif

endmodule
